// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode handshake bundle for the instruction fetch queue
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;

    // master is the pipeline side (fetch + decode + redirect), slave is the queue
    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry {pc, instr} queue between fetch and decode with flush
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // in_ready depends only on occupancy so the PC enable has no path from decode
    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // storage is left uncleared; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) begin
        if (push && reset && !bus.flush) begin
            mem_pc[wr_ptr]    <= bus.in_pc;
            mem_instr[wr_ptr] <= bus.in_instr;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = empty ? 32'h0000_0000 : mem_pc[rd_ptr];
    assign bus.out_instr = empty ? 32'h0000_0000 : mem_instr[rd_ptr];
    assign bus.count     = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized, model-checked bench for fetch_queue
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0]   model_q[$];
    logic [CW-1:0] exp_count;
    logic          exp_valid;
    logic          exp_ready;
    logic [31:0]   exp_pc;
    logic [31:0]   exp_instr;

    // one clock: drive inputs, advance the reference queue, settle for sampling
    task automatic apply(input logic rst_n, input logic fl, input logic iv,
                         input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        bit do_push;
        bit do_pop;
        reset         = rst_n;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        @(posedge clk);
        do_push = iv && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() > 0);
        if (!rst_n || fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, ins});
        end
        exp_count = CW'(model_q.size());
        exp_valid = (model_q.size() > 0);
        exp_ready = (model_q.size() < DEPTH);
        if (model_q.size() > 0) {exp_pc, exp_instr} = model_q[0];
        else                    {exp_pc, exp_instr} = 64'h0;
        #1;
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 32'h1234, 32'h5678, 1'b1);
        vectors++;
        if ({bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr} !==
            {CW'(0), 1'b0, 1'b1, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d valid=%b ready=%b pc=%h instr=%h, want 0 0 1 0 0",
                     bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr);
        end
        apply(1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h3C01_1234, 1'b0);
        vectors++;
        if ({bus.count, bus.out_valid, bus.out_pc, bus.out_instr} !==
            {CW'(1), 1'b1, 32'h0000_3000, 32'h3C01_1234}) begin
            miscompares++;
            $display("FAIL first_push: count=%0d valid=%b pc=%h instr=%h, want 1 1 00003000 3c011234",
                     bus.count, bus.out_valid, bus.out_pc, bus.out_instr);
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 1'b1, 32'h3000 + 32'(4 * i), $urandom, 1'b0);
            vectors++;
            if ({bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr} !==
                {exp_count, exp_valid, exp_ready, exp_pc, exp_instr}) begin
                miscompares++;
                $display("FAIL fill_%0d: count=%0d valid=%b ready=%b pc=%h instr=%h, want %0d %b %b %h %h",
                         i, bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr,
                         exp_count, exp_valid, exp_ready, exp_pc, exp_instr);
            end
        end
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.count !== CW'(4)) begin
            miscompares++;
            $display("FAIL full_stall: ready=%b count=%0d, want 0 4", bus.in_ready, bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.out_pc !== 32'h3000 + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL drain_order_%0d: pc=%h, want %h", i, bus.out_pc, 32'h3000 + 32'(4 * i));
            end
            apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            vectors++;
            if ({bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr} !==
                {exp_count, exp_valid, exp_ready, exp_pc, exp_instr}) begin
                miscompares++;
                $display("FAIL drain_%0d: count=%0d valid=%b ready=%b pc=%h instr=%h, want %0d %b %b %h %h",
                         i, bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr,
                         exp_count, exp_valid, exp_ready, exp_pc, exp_instr);
            end
        end
    endtask

    task automatic test_stream_wrap();
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b0, 1'b1, 32'h3000 + 32'(4 * i), $urandom, 1'b1);
            vectors++;
            if ({bus.count, bus.out_valid, bus.out_pc, bus.out_instr} !==
                {CW'(1), 1'b1, 32'h3000 + 32'(4 * i), exp_instr}) begin
                miscompares++;
                $display("FAIL stream_%0d: count=%0d valid=%b pc=%h instr=%h, want 1 1 %h %h",
                         i, bus.count, bus.out_valid, bus.out_pc, bus.out_instr,
                         32'h3000 + 32'(4 * i), exp_instr);
            end
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b1, 32'h5000 + 32'(4 * i), $urandom, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 32'h5010, $urandom, 1'b1);
        vectors++;
        if ({bus.count, bus.in_ready, bus.out_pc} !== {CW'(3), 1'b1, 32'h5004}) begin
            miscompares++;
            $display("FAIL full_push_pop: count=%0d ready=%b pc=%h, want 3 1 00005004",
                     bus.count, bus.in_ready, bus.out_pc);
        end
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL refused_push_absent: valid=%b pc=%h, want 0", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b1, 32'h3000 + 32'(4 * i), $urandom, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 32'h3010, 32'hDEAD_BEEF, 1'b1);
        vectors++;
        if ({bus.count, bus.out_valid, bus.in_ready, bus.out_instr} !== {CW'(0), 1'b0, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL flush: count=%0d valid=%b ready=%b instr=%h, want 0 0 1 0",
                     bus.count, bus.out_valid, bus.in_ready, bus.out_instr);
        end
        apply(1'b1, 1'b0, 1'b1, 32'h4000, 32'h2402_0001, 1'b0);
        vectors++;
        if ({bus.count, bus.out_pc, bus.out_instr} !== {CW'(1), 32'h4000, 32'h2402_0001}) begin
            miscompares++;
            $display("FAIL post_flush_push: count=%0d pc=%h instr=%h, want 1 00004000 24020001",
                     bus.count, bus.out_pc, bus.out_instr);
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_override();
        for (int i = 0; i < 2; i++) apply(1'b1, 1'b0, 1'b1, 32'h6000 + 32'(4 * i), $urandom, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 32'h6010, 32'h1111_1111, 1'b1);
        vectors++;
        if ({bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr} !==
            {CW'(0), 1'b0, 1'b1, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_over_flush: count=%0d valid=%b ready=%b pc=%h instr=%h, want 0 0 1 0 0",
                     bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr);
        end
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b1, 32'h7000 + 32'(4 * i), $urandom, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 32'h7010, 32'h2222_2222, 1'b1);
        vectors++;
        if ({bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr} !==
            {CW'(0), 1'b0, 1'b1, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_at_full: count=%0d valid=%b ready=%b pc=%h instr=%h, want 0 0 1 0 0",
                     bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0), $urandom, $urandom, ($urandom_range(0, 2) != 0));
            vectors++;
            if ({bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr} !==
                {exp_count, exp_valid, exp_ready, exp_pc, exp_instr}) begin
                miscompares++;
                $display("FAIL random_%0d: count=%0d valid=%b ready=%b pc=%h instr=%h, want %0d %b %b %h %h",
                         i, bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr,
                         exp_count, exp_valid, exp_ready, exp_pc, exp_instr);
            end
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'h0;
        bus.in_instr  = 32'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fill_stall();
        test_stream_wrap();
        test_full_push_pop();
        test_flush();
        test_reset_override();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the PC/instruction-memory fetch stage and the decode stage of the five-stage MIPS pipeline. Each cycle it captures the fetched {PC, instruction} pair and presents the oldest pair to decode through a valid/ready handshake. Fetch can therefore run ahead of decode stalls; its `in_ready` drives the PC register's enable. A flush discards all buffered pairs when a branch or jump redirects fetch.

## Interface
- `DEPTH`, 4: number of entries; power of two, 2..16.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on the `clk` rising edge).
- `in_valid`  in  1  fetch stage presents a pair.
- `in_pc`  in  32  PC of the fetched instruction.
- `in_instr`  in  32  instruction word from instruction memory.
- `in_ready`  out  1  queue can accept a pair; drives the PC enable.
- `out_valid`  out  1  head entry valid for decode.
- `out_pc`  out  32  PC of the head entry.
- `out_instr`  out  32  instruction of the head entry.
- `out_ready`  in  1  decode accepts the head this cycle; 0 while decode is stalled.
- `flush`  in  1  discard all entries; redirect in progress.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage: `DEPTH`-entry array of {pc, instr}, with a write pointer, a read pointer and an occupancy counter.
- Push = `in_valid && in_ready`. Writes the pair at the write pointer and advances the write pointer modulo `DEPTH`.
- Pop = `out_valid && out_ready`. Advances the read pointer modulo `DEPTH`.
- Full is `count == DEPTH`; empty is `count == 0`.
- `in_ready = !full`. It is registered-state based only. There is no combinational path from `out_ready`, so a full queue refuses a push even when a pop happens in the same cycle.
- `out_valid = !empty`.
- `out_pc`/`out_instr` show the entry at the read pointer. When empty they are forced to 32'h0000_0000. An instruction value of 0 is `sll $0,$0,0`, a NOP.
- `in_valid` while `in_ready`=0: the pair is ignored and the queue is unchanged. Upstream holds the PC because the PC enable is low.
- Simultaneous push and pop (not full, not empty): `count` is unchanged and both pointers advance.
- Push into an empty queue: the entry is not bypassed. It appears at the output the next cycle.
- `flush`=1: at the clock edge both pointers reset to 0 and `count` resets to 0. Any same-cycle push or pop is discarded.
- Priority at each edge: reset > flush > push/pop.
- Pointer wrap: after entry `DEPTH-1`, the next write or read uses entry 0. FIFO order is preserved across the wrap.
- The data array is not cleared by reset or flush. Only the pointers and `count` are cleared.

## Timing
- Reset (`reset`=0 at an edge): `count`=0, `out_valid`=0, `out_pc`=0, `out_instr`=0, `in_ready`=1 from the following cycle.
- Latency: a pair pushed at edge k is visible on `out_*` with `out_valid`=1 after edge k (cycle k+1), if the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- `in_ready` falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop from full.
- Flush asserted at edge k: `out_valid`=0 and `in_ready`=1 in cycle k+1. A push at edge k+1 from the redirected PC is accepted.
- Reset asserted mid-operation: same result as a flush, and it overrides `flush`/`in_valid`/`out_ready`.

## Test plan
- Reset then single push: `reset`=0 for 2 cycles, then push {0x0000_3000, 0x3C01_1234} → next cycle `out_valid`=1, `out_pc`=0x3000, `out_instr`=0x3C011234, `count`=1.
- Fill and stall: `out_ready`=0, push PCs 0x3000, 0x3004, 0x3008, 0x300C → `count`=4, `in_ready`=0. A fifth push of 0x3010 is ignored. Releasing `out_ready` yields 0x3000..0x300C in order, with `in_ready`=1 the cycle after the first pop.
- Streaming with wrap: continuous push/pop with `out_ready`=1 for 10 pairs (0x3000..0x3024) → every pair emerges one cycle after its push, in order. `count` stays at 1 and the pointers wrap twice.
- Push+pop when full: `count`=4 with `in_valid`=1 and `out_ready`=1 → the pop occurs, the push is refused, and `count`=3 next cycle.
- Flush mid-stream: 3 entries queued, `flush`=1 with simultaneous `in_valid` (0x3010) and `out_ready` → next cycle `count`=0, `out_valid`=0, `out_instr`=0. A following push of 0x4000 is output alone.
- Reset overrides flush and push: `reset`=0 with `flush`=1, `in_valid`=1 and 2 entries queued → next cycle `count`=0 and outputs are 0. The bench checks the same for reset at the full boundary.
